// File: rtl/spin_seq_ctrl.sv
// Position sequencer for the 6-position spinner decoder: steps num 0..5 at a programmable
// tick rate, counts laps and stops at a lap target. SPIN_REVERSE_EN adds a dir input.
module spin_seq_ctrl #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] laps,
`ifdef SPIN_REVERSE_EN
    input  logic       dir,
`endif
    output logic [3:0] num,
    output logic       busy,
    output logic       done,
    output logic [3:0] lap_cnt
);

    localparam int unsigned NPOS     = 6;
    localparam int unsigned CntW     = 26;
    localparam logic [3:0]  LastPos  = 4'(NPOS - 1);
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSpin,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      num_q, num_d;
    logic [3:0]      lap_q, lap_d;
    logic [3:0]      laps_q, laps_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef SPIN_REVERSE_EN
    logic            dir_q, dir_d;
`endif

    logic       tick;
    logic [3:0] next_pos;
    logic [3:0] lap_inc;

    assign tick    = (cnt_q == TickLast);
    assign lap_inc = (lap_q == 4'hF) ? lap_q : lap_q + 4'd1;

    always_comb begin
        next_pos = (num_q == LastPos) ? 4'd0 : num_q + 4'd1;
`ifdef SPIN_REVERSE_EN
        if (dir_q) begin
            next_pos = (num_q == 4'd0) ? LastPos : num_q - 4'd1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        lap_d   = lap_q;
        laps_d  = laps_q;
`ifdef SPIN_REVERSE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = StSpin;
                    laps_d  = laps;
                    lap_d   = 4'd0;
`ifdef SPIN_REVERSE_EN
                    dir_d   = dir;
`endif
                end
            end
            StSpin: begin
                if (stop) begin
                    // Abort holds num and lap_cnt; the final tick is dropped too.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = '0;
                    num_d = next_pos;
                    if (next_pos == 4'd0) begin
                        lap_d = lap_inc;
                        if (laps_q != 4'd0 && lap_inc == laps_q) begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == StSpin);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            num_q   <= 4'd0;
            lap_q   <= 4'd0;
            laps_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPIN_REVERSE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            lap_q   <= lap_d;
            laps_q  <= laps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPIN_REVERSE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign num     = num_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign lap_cnt = lap_q;

endmodule

// File: tb/tb_spin_seq_ctrl.sv
// Self-checking bench for spin_seq_ctrl; expected values come from a closed-form model of
// position and lap count as a function of cycles elapsed since the accepted start.
module tb_spin_seq_ctrl;

    localparam int TD = 4;
`ifdef SPIN_REVERSE_EN
    localparam bit HaveRev = 1'b1;
`else
    localparam bit HaveRev = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] laps;
    logic       dir;
    logic [3:0] num;
    logic       busy;
    logic       done;
    logic [3:0] lap_cnt;

    int checks   = 0;
    int failures = 0;
    int cur_num  = 0;

    spin_seq_ctrl #(
        .TICK_DIV(TD)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .laps   (laps),
`ifdef SPIN_REVERSE_EN
        .dir    (dir),
`endif
        .num    (num),
        .busy   (busy),
        .done   (done),
        .lap_cnt(lap_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs k cycles after the accepted-start edge, from start position p0.
    function automatic void model(input int p0, input bit rv, input int l, input int k,
                                  output int e_num, output int e_lap,
                                  output bit e_busy, output bit e_done);
        int steps, d, s_end, nl;
        steps = k / TD;
        d = rv ? ((p0 == 0) ? 6 : p0) : 6 - p0;
        if (l != 0) begin
            s_end = d + 6 * (l - 1);
            if (steps >= s_end) begin
                e_num  = 0;
                e_lap  = l;
                e_busy = 1'b0;
                e_done = (k == s_end * TD);
                return;
            end
        end
        e_num  = rv ? (p0 - steps % 6 + 6) % 6 : (p0 + steps) % 6;
        nl     = (steps >= d) ? 1 + (steps - d) / 6 : 0;
        e_lap  = (nl > 15) ? 15 : nl;
        e_busy = 1'b1;
        e_done = 1'b0;
    endfunction

    function automatic int end_k(input int p0, input bit rv, input int l);
        int d;
        d = rv ? ((p0 == 0) ? 6 : p0) : 6 - p0;
        return (l == 0) ? -1 : (d + 6 * (l - 1)) * TD;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the sample point k=0 of the new run.
    task automatic start_run(input int l, input bit rv);
        laps  = 4'(l);
        dir   = rv;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; laps = 4'd0; dir = 1'b0;
        cyc();
        cyc();
        checks++;
        if (num !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || lap_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset got num=%0d busy=%0b done=%0b lap=%0d exp 0/0/0/0",
                     num, busy, done, lap_cnt);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || num !== 4'd0) begin
            failures++;
            $display("FAIL reset_release got busy=%0b num=%0d exp busy=0 num=0", busy, num);
        end
        cur_num = 0;
    endtask

    task automatic test_forward_two_laps();
        int en, el, p0, nd, last;
        bit eb, ed;
        p0 = cur_num; nd = 0;
        last = end_k(p0, 1'b0, 2) + 3;
        start_run(2, 1'b0);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) cyc();
            model(p0, 1'b0, 2, k, en, el, eb, ed);
            if (done === 1'b1) nd++;
            checks++;
            if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL fwd2 k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                         k, num, lap_cnt, busy, done, en, el, eb, ed);
            end
        end
        checks++;
        if (nd != 1) begin
            failures++;
            $display("FAIL fwd2_done_pulses got %0d exp 1", nd);
        end
        cur_num = 0;
    endtask

    task automatic test_abort();
        int en, el, p0, ks;
        bit eb, ed;
        p0 = cur_num;
        ks = ((3 - p0 + 6) % 6 == 0 ? 6 : (3 - p0 + 6) % 6) * TD;
        start_run(0, 1'b0);
        for (int k = 0; k <= ks; k++) begin
            if (k > 0) cyc();
            model(p0, 1'b0, 0, k, en, el, eb, ed);
            checks++;
            if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL abort_run k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                         k, num, lap_cnt, busy, done, en, el, eb, ed);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || num !== 4'd3 || done !== 1'b0 || lap_cnt !== 4'(el)) begin
            failures++;
            $display("FAIL abort_stop got busy=%0b num=%0d done=%0b lap=%0d exp 0/3/0/%0d",
                     busy, num, done, lap_cnt, el);
        end
        cyc(); cyc(); cyc();
        checks++;
        if (num !== 4'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold got num=%0d busy=%0b exp 3/0", num, busy);
        end
        start_run(0, 1'b0);
        for (int k = 0; k <= 3 * TD; k++) begin
            if (k > 0) cyc();
            model(3, 1'b0, 0, k, en, el, eb, ed);
            checks++;
            if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL abort_resume k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                         k, num, lap_cnt, busy, done, en, el, eb, ed);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (lap_cnt !== 4'd1 || num !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_resume_stop got lap=%0d num=%0d busy=%0b exp 1/0/0",
                     lap_cnt, num, busy);
        end
        cur_num = 0;
    endtask

    task automatic test_start_stop_together();
        start = 1'b1; stop = 1'b1; laps = 4'd1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (busy !== 1'b0 || num !== 4'(cur_num)) begin
                failures++;
                $display("FAIL start_stop i=%0d got busy=%0b num=%0d exp 0/%0d",
                         i, busy, num, cur_num);
            end
        end
        start = 1'b0; stop = 1'b0;
        cyc();
    endtask

    task automatic test_start_ignored();
        int en, el, p0, nd, last;
        bit eb, ed;
        p0 = cur_num; nd = 0;
        last = end_k(p0, 1'b0, 1) + 3;
        start_run(1, 1'b0);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) cyc();
            model(p0, 1'b0, 1, k, en, el, eb, ed);
            if (done === 1'b1) nd++;
            checks++;
            if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL start_ign k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                         k, num, lap_cnt, busy, done, en, el, eb, ed);
            end
            if (k == TD + 1) begin start = 1'b1; laps = 4'd3; end
            if (k == 2 * TD + 1) start = 1'b0;
        end
        checks++;
        if (nd != 1 || lap_cnt !== 4'd1) begin
            failures++;
            $display("FAIL start_ign_end got pulses=%0d lap=%0d exp 1/1", nd, lap_cnt);
        end
        cur_num = 0;
    endtask

    task automatic test_stop_on_final_tick();
        int en, el, p0, ke;
        bit eb, ed;
        p0 = cur_num;
        ke = end_k(p0, 1'b0, 1) - 1;
        start_run(1, 1'b0);
        for (int k = 1; k <= ke; k++) cyc();
        model(p0, 1'b0, 1, ke, en, el, eb, ed);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || num !== 4'(en) || lap_cnt !== 4'(el)) begin
            failures++;
            $display("FAIL stop_final got busy=%0b done=%0b num=%0d lap=%0d exp 0/0/%0d/%0d",
                     busy, done, num, lap_cnt, en, el);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_final_after got done=%0b busy=%0b exp 0/0", done, busy);
        end
        cur_num = en;
    endtask

    task automatic test_random();
        int en, el, p0, l, ek, ks, last;
        bit eb, ed, rv, do_stop;
        for (int r = 0; r < 10; r++) begin
            p0 = cur_num;
            l  = $urandom_range(0, 3);
            rv = HaveRev ? 1'($urandom_range(0, 1)) : 1'b0;
            ek = end_k(p0, rv, l);
            do_stop = (l == 0) || ($urandom_range(0, 1) == 1);
            ks = (l == 0) ? $urandom_range(0, 150) : $urandom_range(0, ek - 1);
            last = do_stop ? ks : ek + 2;
            start_run(l, rv);
            for (int k = 0; k <= last; k++) begin
                if (k > 0) cyc();
                model(p0, rv, l, k, en, el, eb, ed);
                checks++;
                if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                    failures++;
                    $display("FAIL rand r=%0d k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                             r, k, num, lap_cnt, busy, done, en, el, eb, ed);
                end
            end
            if (do_stop) begin
                stop = 1'b1;
                cyc();
                stop = 1'b0;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || num !== 4'(en) || lap_cnt !== 4'(el)) begin
                    failures++;
                    $display("FAIL rand_stop r=%0d got busy=%0b done=%0b num=%0d lap=%0d exp 0/0/%0d/%0d",
                             r, busy, done, num, lap_cnt, en, el);
                end
            end
            cur_num = en;
        end
    endtask

    task automatic test_saturation();
        int en, el, p0, last, bad_range, nd;
        bit eb, ed;
        p0 = cur_num; bad_range = 0; nd = 0;
        last = ((6 - p0) + 6 * 16) * TD;
        start_run(0, 1'b0);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) cyc();
            model(p0, 1'b0, 0, k, en, el, eb, ed);
            if (num > 4'd5) bad_range++;
            if (done === 1'b1) nd++;
            checks++;
            if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL sat k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                         k, num, lap_cnt, busy, done, en, el, eb, ed);
            end
        end
        checks++;
        if (lap_cnt !== 4'd15 || bad_range != 0 || nd != 0) begin
            failures++;
            $display("FAIL sat_end got lap=%0d out_of_range=%0d pulses=%0d exp 15/0/0",
                     lap_cnt, bad_range, nd);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cur_num = en;
    endtask

    task automatic test_reverse();
        int en, el, nd, last;
        bit eb, ed;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        nd = 0;
        last = end_k(0, 1'b1, 1) + 2;
        start_run(1, 1'b1);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) cyc();
            model(0, 1'b1, 1, k, en, el, eb, ed);
            if (done === 1'b1) nd++;
            checks++;
            if (num !== 4'(en) || lap_cnt !== 4'(el) || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL rev k=%0d got num=%0d lap=%0d busy=%0b done=%0b exp %0d/%0d/%0b/%0b",
                         k, num, lap_cnt, busy, done, en, el, eb, ed);
            end
        end
        checks++;
        if (nd != 1) begin
            failures++;
            $display("FAIL rev_done_pulses got %0d exp 1", nd);
        end
        cur_num = 0;
    endtask

    task automatic test_reset_mid_run();
        int nd;
        nd = 0;
        start_run(2, 1'b0);
        for (int k = 1; k <= 3 * TD + 2; k++) cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if (num !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || lap_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid got num=%0d busy=%0b done=%0b lap=%0d exp 0/0/0/0",
                     num, busy, done, lap_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 3 * TD; i++) begin
            cyc();
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++;
        if (nd != 0 || num !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_after got active_cycles=%0d num=%0d exp 0/0", nd, num);
        end
        cur_num = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; laps = 4'd0; dir = 1'b0;
        @(negedge clk);
        test_reset();
        test_forward_two_laps();
        test_abort();
        test_start_stop_together();
        test_start_ignored();
        test_stop_on_final_tick();
        test_random();
        test_saturation();
        if (HaveRev) test_reverse();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
